// File: rtl/juez_colision_if.sv
// Hero/collision judge bus: game state, obstacle field and buttons in; result, score and pose out.
interface juez_colision_if;
    logic [2:0]  presente;
    logic        clk_obstaculos;
    logic [20:0] display_obs;
    logic        btn_arriba;
    logic        btn_abajo;
    logic [1:0]  W_or_L;
    logic [7:0]  score;
    logic [1:0]  pose;

    // Driver side (generator, buttons, game FSM)
    modport master (
        output presente, clk_obstaculos, display_obs, btn_arriba, btn_abajo,
        input  W_or_L, score, pose
    );

    // Judge side
    modport slave (
        input  presente, clk_obstaculos, display_obs, btn_arriba, btn_abajo,
        output W_or_L, score, pose
    );
endinterface

// File: rtl/juez_colision.sv
// Hero pose FSM and per-step collision judge; produces win/loss result and score.
module juez_colision #(
    parameter logic [2:0]  OFF        = 3'd0,
    parameter logic [2:0]  WLCM       = 3'd1,
    parameter logic [2:0]  CH         = 3'd2,
    parameter logic [2:0]  GAME       = 3'd3,
    parameter logic [2:0]  WL         = 3'd4,
    parameter logic [2:0]  PA         = 3'd5,
    parameter int unsigned JUMP_TICKS = 2,
    parameter int unsigned WIN_SCORE  = 16
) (
    input  logic           clk,
    input  logic           rst,
    juez_colision_if.slave bus
);

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned SCORE_W = 8;

    localparam logic [1:0] POSE_SUELO    = 2'd0;
    localparam logic [1:0] POSE_SALTO    = 2'd1;
    localparam logic [1:0] POSE_AGACHADO = 2'd2;

    localparam logic [1:0] WL_PLAYING = 2'b00;
    localparam logic [1:0] WL_LOST    = 2'b01;
    localparam logic [1:0] WL_WON     = 2'b10;

    logic               tick_q, tick_d;
    logic               arriba_q, arriba_d;
    logic               jump_req_q, jump_req_d;
    logic               abajo_q, abajo_d;
    logic               eval_q, eval_d;
    logic [1:0]         pose_q, pose_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         wl_q, wl_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic       step_edge_c;
    logic       low_c;
    logic       high_c;
    logic       hit_c;
    logic       clear_c;
    logic [6:0] col_c;
    logic       unused_obs_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q     <= 1'b0;
            arriba_q   <= 1'b0;
            jump_req_q <= 1'b0;
            abajo_q    <= 1'b0;
            eval_q     <= 1'b0;
            pose_q     <= POSE_SUELO;
            cnt_q      <= '0;
            wl_q       <= WL_PLAYING;
            score_q    <= '0;
        end else begin
            tick_q     <= tick_d;
            arriba_q   <= arriba_d;
            jump_req_q <= jump_req_d;
            abajo_q    <= abajo_d;
            eval_q     <= eval_d;
            pose_q     <= pose_d;
            cnt_q      <= cnt_d;
            wl_q       <= wl_d;
            score_q    <= score_d;
        end
    end

    // Next state: edge detection, collision judge, pose FSM, game-state hold/clear
    always_comb begin
        tick_d     = bus.clk_obstaculos;
        arriba_d   = bus.btn_arriba;
        jump_req_d = bus.btn_arriba & ~arriba_q;
        abajo_d    = bus.btn_abajo;
        eval_d     = 1'b0;
        pose_d     = pose_q;
        cnt_d      = cnt_q;
        wl_d       = wl_q;
        score_d    = score_q;
        clear_c    = 1'b0;

        col_c       = bus.display_obs[6:0];
        step_edge_c = bus.clk_obstaculos & ~tick_q;
        low_c       = col_c[2] | col_c[3] | col_c[4];
        high_c      = col_c[0] | col_c[1] | col_c[5];
        hit_c       = (low_c && (pose_q != POSE_SALTO)) ||
                      (high_c && (pose_q != POSE_AGACHADO));

        case (bus.presente)
            GAME: begin
                if (wl_q == WL_PLAYING) begin
                    eval_d = step_edge_c;

                    // Judge the column against the pose held during the step
                    if (eval_q) begin
                        if (hit_c) begin
                            wl_d = WL_LOST;
                        end else if (col_c != 7'd0) begin
                            score_d = score_q + SCORE_W'(1);
                            if ((9'(score_q) + 9'd1) == 9'(WIN_SCORE)) begin
                                wl_d = WL_WON;
                            end
                        end
                    end

                    case (pose_q)
                        POSE_SUELO: begin
                            if (jump_req_q) begin
                                pose_d = POSE_SALTO;
                                cnt_d  = CNT_W'(JUMP_TICKS);
                            end else if (abajo_q) begin
                                pose_d = POSE_AGACHADO;
                            end
                        end
                        POSE_SALTO: begin
                            // One evaluation consumed per step; land when it runs out
                            if (eval_q) begin
                                if (cnt_q <= CNT_W'(1)) begin
                                    cnt_d  = '0;
                                    pose_d = POSE_SUELO;
                                end else begin
                                    cnt_d = cnt_q - CNT_W'(1);
                                end
                            end
                        end
                        POSE_AGACHADO: begin
                            if (!abajo_q) begin
                                pose_d = POSE_SUELO;
                            end
                        end
                        default: begin
                            pose_d = POSE_SUELO;
                            cnt_d  = '0;
                        end
                    endcase
                end
            end
            PA: begin
                // Paused: a step already seen stays pending until play resumes
                eval_d = eval_q;
            end
            OFF, WLCM, CH, WL: clear_c = 1'b1;
            default:           clear_c = 1'b1;
        endcase

        // Any non-play state wipes the round; this releases the generator hold
        if (clear_c) begin
            pose_d  = POSE_SUELO;
            cnt_d   = '0;
            wl_d    = WL_PLAYING;
            score_d = '0;
        end
    end

    // Outputs straight from flops
    always_comb begin
        bus.W_or_L   = wl_q;
        bus.score    = score_q;
        bus.pose     = pose_q;
        unused_obs_c = ^bus.display_obs[20:7];
    end

endmodule
